// File: rtl/ramd16_fifo_ctrl.sv
// Pointer/flag controller turning a bank of 16x1 dual-port distributed RAM cells into a 16-deep show-ahead FIFO.
// Optional registered ALMOST_FULL/ALMOST_EMPTY flags are built only when RAMD16_FIFO_THRESH_EN is defined.
module ramd16_fifo_ctrl #(
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FLUSH,
  input  logic       WR_REQ,
  input  logic       RD_REQ,
  output logic       WE,
  output logic [3:0] WADR,
  output logic [3:0] RADR,
  output logic       FULL,
  output logic       EMPTY,
  output logic [4:0] COUNT,
  output logic       OVERFLOW,
  output logic       UNDERFLOW,
  output logic       ALMOST_FULL,
  output logic       ALMOST_EMPTY
);

  if (AFULL_THRESH < 1 || AFULL_THRESH > 16 ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > 15) begin : g_bad_thresh
    $error("ramd16_fifo_ctrl: threshold parameter out of range");
  end

  logic       clear;
  logic       push_ok;
  logic       pop_ok;
  logic [4:0] count_nxt;

  assign clear   = RST | FLUSH;
  assign FULL    = (COUNT == 5'd16);
  assign EMPTY   = (COUNT == 5'd0);

  // On a full FIFO a simultaneous pop frees the slot being written this edge.
  assign push_ok = WR_REQ & (~FULL | RD_REQ);
  assign pop_ok  = RD_REQ & ~EMPTY;
  assign WE      = push_ok & ~clear;

  always_comb begin
    count_nxt = COUNT;
    if (clear) begin
      count_nxt = 5'd0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = COUNT + 5'd1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = COUNT - 5'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      WADR      <= 4'd0;
      RADR      <= 4'd0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (push_ok) WADR <= WADR + 4'd1;
      if (pop_ok)  RADR <= RADR + 4'd1;
      OVERFLOW  <= WR_REQ & ~push_ok;
      UNDERFLOW <= RD_REQ & ~pop_ok;
    end
    COUNT <= count_nxt;
  end

`ifdef RAMD16_FIFO_THRESH_EN
  localparam logic [4:0] AF_LVL = 5'(AFULL_THRESH);
  localparam logic [4:0] AE_LVL = 5'(AEMPTY_THRESH);

  // Compared against next-state count so the flags change on the same edge as COUNT.
  always_ff @(posedge CLK) begin
    ALMOST_FULL  <= (count_nxt >= AF_LVL);
    ALMOST_EMPTY <= (count_nxt <= AE_LVL);
  end
`else
  assign ALMOST_FULL  = 1'b0;
  assign ALMOST_EMPTY = 1'b0;
`endif

endmodule

// File: tb/tb_ramd16_fifo_ctrl.sv
// Scoreboard bench for ramd16_fifo_ctrl: an 8-bit RAM bank model plus a queue-based FIFO reference.
module tb_ramd16_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic       we;
  logic [3:0] wadr, radr;
  logic       full, empty, overflow, underflow, almost_full, almost_empty;
  logic [4:0] count;

  ramd16_fifo_ctrl dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .WR_REQ(wr_req), .RD_REQ(rd_req),
    .WE(we), .WADR(wadr), .RADR(radr), .FULL(full), .EMPTY(empty), .COUNT(count),
    .OVERFLOW(overflow), .UNDERFLOW(underflow),
    .ALMOST_FULL(almost_full), .ALMOST_EMPTY(almost_empty)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [16];
  always @(posedge clk) if (we) ram[wadr] <= wdata;

  typedef struct {
    bit         we;
    bit         pop;
    logic [7:0] head;
    int         cnt;
    int         wa;
    int         ra;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       sb[$];
  exp_t       pend;
  bit         have_pend = 0;
  int         checks = 0;
  int         failures = 0;

  logic [7:0] mq[$];
  int         m_wp = 0;
  int         m_rp = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endfunction

  // Checks the settled outputs of the previous edge, then this cycle's combinational outputs.
  always @(negedge clk) begin
    if (have_pend) begin
      chk("count", 32'(count), 32'(pend.cnt));
      chk("full", 32'(full), 32'(pend.cnt == 16));
      chk("empty", 32'(empty), 32'(pend.cnt == 0));
      chk("wadr", 32'(wadr), 32'(pend.wa));
      chk("radr", 32'(radr), 32'(pend.ra));
      chk("overflow", 32'(overflow), 32'(pend.ovf));
      chk("underflow", 32'(underflow), 32'(pend.unf));
`ifdef RAMD16_FIFO_THRESH_EN
      chk("almost_full", 32'(almost_full), 32'(pend.cnt >= 14));
      chk("almost_empty", 32'(almost_empty), 32'(pend.cnt <= 2));
`else
      chk("almost_full", 32'(almost_full), 32'd0);
      chk("almost_empty", 32'(almost_empty), 32'd0);
`endif
    end
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("we", 32'(we), 32'(e.we));
      if (e.pop) chk("head_data", 32'(ram[radr]), 32'(e.head));
      pend      = e;
      have_pend = 1;
    end
  end

  task automatic cycle(input bit r, input bit f, input bit w, input bit rd, input logic [7:0] d);
    exp_t e;
    bit   is_full;
    @(posedge clk);
    #1;
    rst = r; flush = f; wr_req = w; rd_req = rd; wdata = d;
    e = '{we: 0, pop: 0, head: 8'd0, cnt: 0, wa: 0, ra: 0, ovf: 0, unf: 0};
    if (r || f) begin
      mq.delete();
      m_wp = 0;
      m_rp = 0;
    end else begin
      is_full = (mq.size() == 16);
      e.we  = w && (!is_full || rd);
      e.pop = rd && (mq.size() > 0);
      e.ovf = w && !e.we;
      e.unf = rd && !e.pop;
      if (e.pop) begin
        e.head = mq.pop_front();
        m_rp   = (m_rp + 1) % 16;
      end
      if (e.we) begin
        mq.push_back(d);
        m_wp = (m_wp + 1) % 16;
      end
    end
    e.cnt = mq.size();
    e.wa  = m_wp;
    e.ra  = m_rp;
    sb.push_back(e);
  endtask

  initial begin
    int wr_pct, rd_pct;
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0, 8'(i));
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 8'(8'h40 + i));
    cycle(0, 0, 1, 1, 8'h0A);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 0, 1, 1, 8'h5B);
    cycle(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 8'(8'h70 + i));
    cycle(0, 1, 1, 0, 8'hEE);
    cycle(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 8'(8'h80 + i));
    cycle(1, 0, 1, 1, 8'hEE);
    cycle(0, 0, 0, 0, 8'h00);
    for (int seg = 0; seg < 30; seg++) begin
      wr_pct = (seg % 3 == 0) ? 85 : (seg % 3 == 1) ? 20 : 55;
      rd_pct = (seg % 3 == 0) ? 25 : (seg % 3 == 1) ? 85 : 55;
      for (int i = 0; i < 60; i++) begin
        cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
              8'($urandom));
      end
    end
    cycle(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
